// File: rtl/single_port_ram.sv
// Synchronous single-port scratch RAM with one shared address bus.
// Registered read port, one access per clock, synchronous clear of array and output.
module single_port_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  ce,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;
    logic                  we;
    logic                  re;

    assign we = ce & wr;
    assign re = ce & ~wr;

    // Read sees the array as it stood before this edge; a write never updates dout.
    always_comb begin
        dout_d = dout_q;
        if (re) begin
            dout_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            dout_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            dout_q <= dout_d;
            if (we) begin
                mem_q[addr] <= din;
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_single_port_ram.sv
// Directed vector table plus randomized traffic against a plain array model
// for the 256x16 single-port RAM.
module tb_single_port_ram;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int N  = 2 ** AW;

    logic          clk = 1'b0;
    logic          nrst;
    logic          ce;
    logic          wr;
    logic [DW-1:0] din;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [N];
    logic [DW-1:0] ref_dout;

    typedef struct {
        logic          nrst;
        logic          ce;
        logic          wr;
        logic [DW-1:0] din;
        logic [AW-1:0] addr;
        bit            chk;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    single_port_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .ce  (ce),
        .wr  (wr),
        .din (din),
        .addr(addr),
        .dout(dout)
    );

    always #5 clk = ~clk;

    function automatic void push(input logic n, input logic c, input logic w,
                                 input logic [DW-1:0] d, input logic [AW-1:0] a,
                                 input logic [DW-1:0] e);
        vec_t v;
        v.nrst = n;
        v.ce   = c;
        v.wr   = w;
        v.din  = d;
        v.addr = a;
        v.chk  = 1'b1;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    // Behavioural memory: what one clock edge means, in plain array terms.
    task automatic model_edge(input logic n, input logic c, input logic w,
                              input logic [DW-1:0] d, input logic [AW-1:0] a);
        if (!n) begin
            foreach (ref_mem[i]) ref_mem[i] = '0;
            ref_dout = '0;
        end else if (c && w) begin
            ref_mem[a] = d;
        end else if (c) begin
            ref_dout = ref_mem[a];
        end
    endtask

    task automatic drive(input logic n, input logic c, input logic w,
                         input logic [DW-1:0] d, input logic [AW-1:0] a);
        @(negedge clk);
        nrst = n;
        ce   = c;
        wr   = w;
        din  = d;
        addr = a;
        @(posedge clk);
        model_edge(n, c, w, d, a);
        #1;
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [AW-1:0] ra;
        nrst = 1'b0;
        ce   = 1'b0;
        wr   = 1'b0;
        din  = '0;
        addr = '0;

        // 1: reset and basic write/read
        push(0, 1, 1, 16'h1111, 8'h00, 16'h0000);
        push(0, 0, 0, 16'h0000, 8'h00, 16'h0000);
        push(1, 1, 1, 16'h0077, 8'h00, 16'h0000);
        push(1, 1, 1, 16'h00EE, 8'h01, 16'h0000);
        push(1, 1, 0, 16'h0000, 8'h00, 16'h0077);
        push(1, 1, 0, 16'h0000, 8'h01, 16'h00EE);
        // 2: iterated pattern, then re-read 0/1
        for (int i = 0; i < 3; i++) begin
            push(1, 1, 1, 16'(16'h77 + i), 8'(2 * i), 16'h00EE - 16'(i == 0 ? 0 : 1) * 16'(i == 0 ? 0 : (16'h00EE - 16'h00EC - i + 3)));
            vecs[$].chk = 1'b0;
            push(1, 1, 1, 16'(16'hEE - i), 8'(2 * i + 1), 16'h0000);
            vecs[$].chk = 1'b0;
            push(1, 1, 0, 16'h0000, 8'(2 * i), 16'(16'h77 + i));
            push(1, 1, 0, 16'h0000, 8'(2 * i + 1), 16'(16'hEE - i));
        end
        push(1, 1, 0, 16'h0000, 8'h02, 16'h0078);
        push(1, 1, 0, 16'h0000, 8'h03, 16'h00ED);
        push(1, 1, 0, 16'h0000, 8'h04, 16'h0079);
        push(1, 1, 0, 16'h0000, 8'h05, 16'h00EC);
        push(1, 1, 0, 16'h0000, 8'h00, 16'h0077);
        push(1, 1, 0, 16'h0000, 8'h01, 16'h00EE);
        // 3: chip enable off, hostile inputs
        push(1, 0, 1, 16'hFFFF, 8'h00, 16'h00EE);
        push(1, 0, 0, 16'hFFFF, 8'h01, 16'h00EE);
        push(1, 0, 1, 16'hxxxx, 8'h02, 16'h00EE);
        push(1, 1, 0, 16'hxxxx, 8'h01, 16'h00EE);
        push(1, 1, 0, 16'h0000, 8'h02, 16'h0078);
        push(1, 1, 0, 16'h0000, 8'h00, 16'h0077);
        // 4: write leaves dout alone
        push(1, 1, 1, 16'h1234, 8'h05, 16'h0077);
        push(1, 1, 0, 16'h0000, 8'h05, 16'h1234);
        // 5: reset mid-operation with a pending write
        push(0, 1, 1, 16'hBEEF, 8'h03, 16'h0000);
        push(0, 1, 1, 16'hBEEF, 8'h04, 16'h0000);
        for (int a = 0; a < 6; a++) push(1, 1, 0, 16'h0000, 8'(a), 16'h0000);
        // 6: boundary addresses
        push(1, 1, 1, 16'hA5A5, 8'hFF, 16'h0000);
        push(1, 1, 1, 16'h5A5A, 8'h00, 16'h0000);
        push(1, 1, 0, 16'h0000, 8'hFF, 16'hA5A5);
        push(1, 1, 0, 16'h0000, 8'h00, 16'h5A5A);
        push(1, 1, 0, 16'h0000, 8'h80, 16'h0000);

        foreach (vecs[k]) begin
            drive(vecs[k].nrst, vecs[k].ce, vecs[k].wr, vecs[k].din, vecs[k].addr);
            if (vecs[k].chk) begin
                checks++;
                if (dout !== vecs[k].exp) begin
                    errors++;
                    $display("FAIL vec%0d dout got %h want %h", k, dout, vecs[k].exp);
                end
            end
        end

        // Randomized traffic; narrow address window half the time for reuse.
        for (int t = 0; t < 2000; t++) begin
            ra = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            rd = 16'($urandom);
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), rd, ra);
            checks++;
            if (dout !== ref_dout) begin
                errors++;
                $display("FAIL rand%0d dout got %h want %h", t, dout, ref_dout);
            end
        end

        // Full sweep of every address against the model.
        for (int a = 0; a < N; a++) begin
            drive(1, 1, 0, 16'h0000, 8'(a));
            checks++;
            if (dout !== ref_dout) begin
                errors++;
                $display("FAIL sweep%0d dout got %h want %h", a, dout, ref_dout);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
